// File: rtl/unet_pkg.sv
// rtl/unet_pkg.sv - shared state encoding and dimension helpers for U-Net pool/upsample stages
package unet_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD_ROW,
    EMIT,
    DRAIN,
    DONE
  } unet_state_e;

  localparam int DATA_WIDTH_DEFAULT = 16;

  function automatic int scaled_dim(input int in_dim, input int scale);
    return in_dim * scale;
  endfunction

  function automatic int cnt_width(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/upsample_line_buffer.sv
// rtl/upsample_line_buffer.sv - single-row buffer, synchronous write, asynchronous read
module upsample_line_buffer
  import unet_pkg::*;
#(
  parameter int DEPTH      = 128,
  parameter int DATA_WIDTH = DATA_WIDTH_DEFAULT,
  parameter int ADDR_WIDTH = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                  clk,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/upsample2d_nearest.sv
// rtl/upsample2d_nearest.sv - nearest-neighbour 2-D upsampler, one row buffered at a time
module upsample2d_nearest
  import unet_pkg::*;
#(
  parameter int IN_HEIGHT  = 128,
  parameter int IN_WIDTH   = 128,
  parameter int CHANNELS   = 64,
  parameter int SCALE      = 2,
  parameter int DATA_WIDTH = DATA_WIDTH_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] feature_in,
  input  logic                  feature_valid,
  output logic                  feature_ready,
  output logic [DATA_WIDTH-1:0] feature_out,
  output logic                  feature_valid_out,
  input  logic                  feature_ready_out,
  output logic                  upsample_done
);

  localparam int OUT_WIDTH = scaled_dim(IN_WIDTH, SCALE);
  localparam int COL_W     = cnt_width(IN_WIDTH);
  localparam int OCOL_W    = cnt_width(OUT_WIDTH);
  localparam int REP_W     = cnt_width(SCALE);
  localparam int ROW_W     = cnt_width(IN_HEIGHT);
  localparam int CH_W      = cnt_width(CHANNELS);
  localparam int LB_AW     = (IN_WIDTH > 1) ? $clog2(IN_WIDTH) : 1;

  localparam logic [COL_W-1:0]  COL_LAST  = COL_W'(IN_WIDTH - 1);
  localparam logic [OCOL_W-1:0] OCOL_LAST = OCOL_W'(OUT_WIDTH - 1);
  localparam logic [REP_W-1:0]  REP_LAST  = REP_W'(SCALE - 1);
  localparam logic [ROW_W-1:0]  ROW_LAST  = ROW_W'(IN_HEIGHT - 1);
  localparam logic [CH_W-1:0]   CH_LAST   = CH_W'(CHANNELS - 1);
  localparam logic [OCOL_W-1:0] SCALE_O   = OCOL_W'(SCALE);

  unet_state_e           state;
  logic [COL_W-1:0]      in_col;
  logic [OCOL_W-1:0]     out_col;
  logic [REP_W-1:0]      rep_row;
  logic [ROW_W-1:0]      in_row;
  logic [CH_W-1:0]       channel;
  logic                  in_fire;
  logic                  out_fire;
  logic                  out_free;
  logic [LB_AW-1:0]      lb_wr_addr;
  logic [LB_AW-1:0]      lb_rd_addr;
  logic [DATA_WIDTH-1:0] lb_rd_data;

  assign in_fire    = feature_valid && feature_ready;
  assign out_fire   = feature_valid_out && feature_ready_out;
  assign out_free   = !feature_valid_out || feature_ready_out;
  assign lb_wr_addr = LB_AW'(in_col);
  // Each buffered pixel is read SCALE times in a row to replicate it horizontally.
  assign lb_rd_addr = LB_AW'(out_col / SCALE_O);

  upsample_line_buffer #(
    .DEPTH     (IN_WIDTH),
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(LB_AW)
  ) u_line_buffer (
    .clk    (clk),
    .wr_en  (in_fire),
    .wr_addr(lb_wr_addr),
    .wr_data(feature_in),
    .rd_addr(lb_rd_addr),
    .rd_data(lb_rd_data)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state             <= IDLE;
      in_col            <= '0;
      out_col           <= '0;
      rep_row           <= '0;
      in_row            <= '0;
      channel           <= '0;
      feature_out       <= '0;
      feature_valid_out <= 1'b0;
      feature_ready     <= 1'b0;
      upsample_done     <= 1'b0;
    end else begin
      upsample_done <= 1'b0;
      // An accepted word drops valid unless EMIT reloads the register below.
      if (out_fire) begin
        feature_valid_out <= 1'b0;
      end
      case (state)
        IDLE: begin
          if (start) begin
            state         <= LOAD_ROW;
            feature_ready <= 1'b1;
            in_col        <= '0;
            out_col       <= '0;
            rep_row       <= '0;
            in_row        <= '0;
            channel       <= '0;
          end
        end
        LOAD_ROW: begin
          if (in_fire) begin
            if (in_col == COL_LAST) begin
              state         <= EMIT;
              feature_ready <= 1'b0;
              in_col        <= '0;
              out_col       <= '0;
              rep_row       <= '0;
            end else begin
              in_col <= in_col + COL_W'(1);
            end
          end
        end
        EMIT: begin
          if (out_free) begin
            feature_out       <= lb_rd_data;
            feature_valid_out <= 1'b1;
            if (out_col == OCOL_LAST) begin
              out_col <= '0;
              if (rep_row == REP_LAST) begin
                rep_row <= '0;
                if (in_row == ROW_LAST) begin
                  in_row <= '0;
                  if (channel == CH_LAST) begin
                    state <= DRAIN;
                  end else begin
                    channel       <= channel + CH_W'(1);
                    state         <= LOAD_ROW;
                    feature_ready <= 1'b1;
                  end
                end else begin
                  in_row        <= in_row + ROW_W'(1);
                  state         <= LOAD_ROW;
                  feature_ready <= 1'b1;
                end
              end else begin
                rep_row <= rep_row + REP_W'(1);
              end
            end else begin
              out_col <= out_col + OCOL_W'(1);
            end
          end
        end
        DRAIN: begin
          if (out_fire) begin
            state         <= DONE;
            upsample_done <= 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_upsample2d_nearest.sv
// tb/tb_upsample2d_nearest.sv - directed table-driven bench for upsample2d_nearest
module tb_upsample2d_nearest;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_s [3];
  logic [15:0] fin     [3];
  logic        fval    [3];
  logic        frdy    [3];
  logic [15:0] fout    [3];
  logic        fvo     [3];
  logic        rdy_out [3];
  logic        done_s  [3];

  always #5 clk = ~clk;

  upsample2d_nearest #(.IN_HEIGHT(2), .IN_WIDTH(2), .CHANNELS(1), .SCALE(2), .DATA_WIDTH(16)) u_a (
    .clk(clk), .rst(rst), .start(start_s[0]), .feature_in(fin[0]), .feature_valid(fval[0]),
    .feature_ready(frdy[0]), .feature_out(fout[0]), .feature_valid_out(fvo[0]),
    .feature_ready_out(rdy_out[0]), .upsample_done(done_s[0]));

  upsample2d_nearest #(.IN_HEIGHT(3), .IN_WIDTH(4), .CHANNELS(2), .SCALE(1), .DATA_WIDTH(16)) u_b (
    .clk(clk), .rst(rst), .start(start_s[1]), .feature_in(fin[1]), .feature_valid(fval[1]),
    .feature_ready(frdy[1]), .feature_out(fout[1]), .feature_valid_out(fvo[1]),
    .feature_ready_out(rdy_out[1]), .upsample_done(done_s[1]));

  upsample2d_nearest #(.IN_HEIGHT(4), .IN_WIDTH(4), .CHANNELS(2), .SCALE(2), .DATA_WIDTH(16)) u_c (
    .clk(clk), .rst(rst), .start(start_s[2]), .feature_in(fin[2]), .feature_valid(fval[2]),
    .feature_ready(frdy[2]), .feature_out(fout[2]), .feature_valid_out(fvo[2]),
    .feature_ready_out(rdy_out[2]), .upsample_done(done_s[2]));

  typedef struct {
    int dut;
    int h;
    int w;
    int c;
    int s;
    bit stall;
    bit spam;
    int base;
  } run_t;

  run_t        runs [4];
  logic [15:0] hand_2x2  [16];
  logic [15:0] hand_beef [16];
  logic [15:0] src   [$];
  logic [15:0] exp_q [$];
  logic [15:0] got   [$];
  int          acc_mark [$];
  int          in_cyc   [$];
  int          n_vec = 0;
  int          n_bad = 0;
  int          done_cnt, done_cyc, last_acc, first_vo, hold_err, idle_err;

  task automatic check_eq(input string name, input logic [63:0] act, input logic [63:0] req);
    n_vec++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, req, req);
    end
  endtask

  task automatic fill_ramp(input int n, input int base);
    src.delete();
    for (int i = 0; i < n; i++) src.push_back(16'(base + i));
  endtask

  task automatic build_exp(input int h, input int w, input int c, input int s);
    exp_q.delete();
    for (int ch = 0; ch < c; ch++)
      for (int oy = 0; oy < h * s; oy++)
        for (int ox = 0; ox < w * s; ox++)
          exp_q.push_back(src[ch * h * w + (oy / s) * w + ox / s]);
  endtask

  task automatic cmp_stream(input string name);
    int bad_words = 0;
    check_eq($sformatf("%s.count", name), got.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++)
      if (i >= got.size() || got[i] !== exp_q[i]) bad_words++;
    check_eq($sformatf("%s.bad_words", name), bad_words, 0);
  endtask

  // Drives one tensor through DUT d: upstream streams src, downstream optionally stalls.
  task automatic run(input int d, input bit stall, input bit spam, input int abort_at);
    int          in_idx = 0;
    int          stop_at = -1;
    bit          prev_stall = 1'b0;
    logic [15:0] prev_out = '0;
    got.delete();
    acc_mark.delete();
    in_cyc.delete();
    done_cnt = 0; done_cyc = -1; last_acc = -1; first_vo = -1; hold_err = 0; idle_err = 0;
    @(negedge clk);
    start_s[d] = 1'b1;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      if (prev_stall && (fvo[d] !== 1'b1 || fout[d] !== prev_out)) hold_err++;
      if (stop_at >= 0 && frdy[d] === 1'b1) idle_err++;
      start_s[d] = spam && (cyc % 2 == 1) && (stop_at < 0);
      fval[d]    = (in_idx < src.size());
      fin[d]     = fval[d] ? src[in_idx] : 16'h0;
      rdy_out[d] = !stall || (cyc % 3 == 0);
      if (first_vo < 0 && fvo[d] === 1'b1) first_vo = cyc;
      if (done_s[d] === 1'b1) begin
        done_cnt++;
        if (stop_at < 0) begin
          done_cyc   = cyc;
          stop_at    = cyc + 4;
          start_s[d] = spam;
        end
      end
      if (fval[d] && frdy[d] === 1'b1) begin
        acc_mark.push_back(got.size());
        in_cyc.push_back(cyc);
        in_idx++;
      end
      if (fvo[d] === 1'b1 && rdy_out[d]) begin
        got.push_back(fout[d]);
        last_acc = cyc;
      end
      prev_stall = (fvo[d] === 1'b1) && !rdy_out[d];
      prev_out   = fout[d];
      if (cyc == stop_at) break;
      if (abort_at > 0 && got.size() >= abort_at) break;
    end
    start_s[d] = 1'b0;
    fval[d]    = 1'b0;
    rdy_out[d] = 1'b1;
  endtask

  initial begin
    hand_2x2  = '{16'd1, 16'd1, 16'd2, 16'd2, 16'd1, 16'd1, 16'd2, 16'd2,
                  16'd3, 16'd3, 16'd4, 16'd4, 16'd3, 16'd3, 16'd4, 16'd4};
    hand_beef = '{16'd1, 16'd1, 16'd2, 16'd2, 16'd1, 16'd1, 16'd2, 16'd2,
                  16'hBEEF, 16'hBEEF, 16'd4, 16'd4, 16'hBEEF, 16'hBEEF, 16'd4, 16'd4};
    runs[0] = '{0, 2, 2, 1, 2, 1'b0, 1'b0, 1};
    runs[1] = '{0, 2, 2, 1, 2, 1'b1, 1'b0, 1};
    runs[2] = '{1, 3, 4, 2, 1, 1'b0, 1'b0, 0};
    runs[3] = '{2, 4, 4, 2, 2, 1'b0, 1'b1, 100};

    rst = 1'b1;
    for (int d = 0; d < 3; d++) begin
      start_s[d] = 1'b0; fval[d] = 1'b0; fin[d] = '0; rdy_out[d] = 1'b1;
    end
    repeat (3) @(negedge clk);
    for (int d = 0; d < 3; d++)
      check_eq($sformatf("reset%0d.outputs", d), {frdy[d], fvo[d], done_s[d], fout[d]}, 0);
    rst = 1'b0;

    for (int i = 0; i < 4; i++) begin
      string nm;
      nm = $sformatf("run%0d", i);
      fill_ramp(runs[i].h * runs[i].w * runs[i].c, runs[i].base);
      if (runs[i].dut == 0) begin
        exp_q.delete();
        foreach (hand_2x2[k]) exp_q.push_back(hand_2x2[k]);
      end else begin
        build_exp(runs[i].h, runs[i].w, runs[i].c, runs[i].s);
      end
      run(runs[i].dut, runs[i].stall, runs[i].spam, 0);
      if (runs[i].dut == 0) begin
        check_eq($sformatf("%s.count", nm), got.size(), 16);
        for (int k = 0; k < 16; k++)
          check_eq($sformatf("%s.word%0d", nm, k), (k < got.size()) ? got[k] : 16'hxxxx, exp_q[k]);
      end else begin
        cmp_stream(nm);
      end
      check_eq($sformatf("%s.done_pulses", nm), done_cnt, 1);
      check_eq($sformatf("%s.done_after_last", nm), done_cyc - last_acc, 1);
      if (runs[i].stall) check_eq($sformatf("%s.stall_hold_errors", nm), hold_err, 0);
      if (runs[i].spam)  check_eq($sformatf("%s.start_in_done_taken", nm), idle_err, 0);
      if (i == 0) check_eq("run0.first_out_latency", first_vo - ((in_cyc.size() > 1) ? in_cyc[1] : -100), 2);
    end

    fill_ramp(32, 500);
    build_exp(4, 4, 2, 2);
    run(2, 1'b0, 1'b0, 5);
    check_eq("abort.words_before_reset", got.size(), 5);
    rst = 1'b1;
    @(negedge clk);
    check_eq("abort.outputs_after_reset", {frdy[2], fvo[2], done_s[2], fout[2]}, 0);
    rst = 1'b0;
    begin
      int activity = 0;
      repeat (4) begin
        @(negedge clk);
        if (frdy[2] !== 1'b0 || fvo[2] !== 1'b0) activity++;
      end
      check_eq("abort.idle_after_reset", activity, 0);
    end
    run(2, 1'b0, 1'b0, 0);
    cmp_stream("rerun");
    check_eq("rerun.done_pulses", done_cnt, 1);

    src.delete();
    src.push_back(16'd1); src.push_back(16'd2); src.push_back(16'hBEEF); src.push_back(16'd4);
    exp_q.delete();
    foreach (hand_beef[k]) exp_q.push_back(hand_beef[k]);
    run(0, 1'b0, 1'b0, 0);
    check_eq("beef.inputs_taken", acc_mark.size(), 4);
    check_eq("beef.outputs_before_accept", (acc_mark.size() > 2) ? acc_mark[2] : -1, 7);
    cmp_stream("beef");
    check_eq("beef.done_pulses", done_cnt, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
